// File: rtl/rms_level.sv
// rtl/rms_level.sv - decimated mean-square to RMS converter with restoring integer square root
// Optional peak-hold register enabled by RMS_LEVEL_PEAK_HOLD_EN.
module rms_level #(
    parameter int SUM_W    = 49,
    parameter int WIN_LOG2 = 12,
    parameter int DECIM    = 256,
    parameter int RMS_W    = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SUM_W-1:0] sum_in,
    input  logic             window_full,
    input  logic             peak_clr,
    output logic [RMS_W-1:0] rms,
    output logic             rms_valid,
    output logic             busy,
    output logic [RMS_W-1:0] peak
);
    localparam int RAD_W = 2 * RMS_W;
    localparam int REM_W = RMS_W + 2;
    localparam int ICW   = $clog2(RMS_W);
    localparam logic [15:0]    DECIM_LAST = 16'(DECIM - 1);
    localparam logic [ICW-1:0] ICNT_LAST  = ICW'(RMS_W - 1);

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t             r_state;
    logic [15:0]        r_dcnt;
    logic [RAD_W-1:0]   r_rad;
    logic [REM_W-1:0]   r_rem;
    logic [RMS_W-1:0]   r_root;
    logic [ICW-1:0]     r_icnt;
    logic [RMS_W-1:0]   r_rms;
    logic               r_rms_valid;
    logic               r_busy;

    logic               w_tick;
    logic [REM_W-1:0]   w_rem_sh;
    logic [REM_W-1:0]   w_trial;
    logic               w_ge;

    assign w_tick   = window_full && (r_dcnt == DECIM_LAST);
    // Bring down the next two radicand bits and test against 4*root+1.
    assign w_rem_sh = {r_rem[REM_W-3:0], r_rad[RAD_W-1 -: 2]};
    assign w_trial  = {r_root, 2'b01};
    assign w_ge     = (w_rem_sh >= w_trial);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_dcnt      <= '0;
            r_rad       <= '0;
            r_rem       <= '0;
            r_root      <= '0;
            r_icnt      <= '0;
            r_rms       <= '0;
            r_rms_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            if (!window_full || r_dcnt == DECIM_LAST)
                r_dcnt <= '0;
            else
                r_dcnt <= r_dcnt + 16'd1;

            r_rms_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_tick) begin
                        r_rad   <= RAD_W'(sum_in[SUM_W-1:WIN_LOG2]);
                        r_rem   <= '0;
                        r_root  <= '0;
                        r_icnt  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ITER;
                    end
                end
                ITER: begin
                    r_rad <= r_rad << 2;
                    if (w_ge) begin
                        r_rem  <= w_rem_sh - w_trial;
                        r_root <= {r_root[RMS_W-2:0], 1'b1};
                    end else begin
                        r_rem  <= w_rem_sh;
                        r_root <= {r_root[RMS_W-2:0], 1'b0};
                    end
                    r_icnt <= r_icnt + 1'b1;
                    if (r_icnt == ICNT_LAST)
                        r_state <= DONE;
                end
                DONE: begin
                    r_rms       <= r_root;
                    r_rms_valid <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign rms       = r_rms;
    assign rms_valid = r_rms_valid;
    assign busy      = r_busy;

`ifdef RMS_LEVEL_PEAK_HOLD_EN
    logic [RMS_W-1:0] r_peak;
    logic             w_unused;

    // A clear coinciding with a publish restarts the hold from the new result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_peak <= '0;
        else if (r_state == DONE)
            r_peak <= (peak_clr || r_root > r_peak) ? r_root : r_peak;
        else if (peak_clr)
            r_peak <= '0;
    end

    assign peak     = r_peak;
    assign w_unused = &{1'b0, sum_in[WIN_LOG2-1:0]};
`else
    logic w_unused;

    assign peak     = '0;
    assign w_unused = &{1'b0, peak_clr, sum_in[WIN_LOG2-1:0]};
`endif
endmodule

// File: tb/tb_rms_level.sv
// tb/tb_rms_level.sv - directed self-checking bench for rms_level
module tb_rms_level;
    logic        clk = 1'b0;
    logic        rst;
    logic [48:0] sum_in;
    logic        window_full;
    logic        peak_clr;
    logic [18:0] rms;
    logic        rms_valid;
    logic        busy;
    logic [18:0] peak;

    int n_pass  = 0;
    int n_total = 0;

`ifdef RMS_LEVEL_PEAK_HOLD_EN
    localparam bit PK = 1'b1;
`else
    localparam bit PK = 1'b0;
`endif

    rms_level dut (
        .clk        (clk),
        .rst        (rst),
        .sum_in     (sum_in),
        .window_full(window_full),
        .peak_clr   (peak_clr),
        .rms        (rms),
        .rms_valid  (rms_valid),
        .busy       (busy),
        .peak       (peak)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic wait_valid(input int bound, output int n);
        n = -1;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clk);
            if (rms_valid === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_busy(input int bound, output int n);
        n = -1;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clk);
            if (busy === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic run_vec(input logic [48:0] s, input logic [18:0] exp, input string tag);
        int n;
        sum_in = s;
        wait_valid(300, n);
        chk({tag, "_seen"}, (n > 0), 1);
        chk(tag, rms, exp);
    endtask

    initial begin
        int n;
        int nb;
        bit bad;

        rst = 1'b1; window_full = 1'b0; peak_clr = 1'b0; sum_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_rms", rms, 0);
        chk("rst_valid", rms_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_peak", peak, 0);
        rst = 1'b0;

        // Constant sum: first result 256+20 cycles after window_full rises.
        sum_in = 49'd4096000000;
        window_full = 1'b1;
        wait_valid(400, n);
        chk("first_latency", n, 276);
        chk("rms_1000", rms, 1000);
        wait_valid(300, n);
        chk("period", n, 256);
        @(negedge clk);
        chk("valid_pulse_width", rms_valid, 0);
        wait_busy(300, nb);
        chk("busy_seen", (nb > 0), 1);
        wait_valid(40, n);
        chk("capture_to_valid", n, 20);
        chk("rms_1000_b", rms, 1000);

        run_vec(49'd405504, 19'd9, "rms_nonsquare");
        run_vec({49{1'b1}}, 19'd370727, "rms_fullscale");
        chk("peak_fullscale", peak, PK ? 370727 : 0);
        run_vec(49'd0, 19'd0, "rms_zero");

        // Sampling isolation: sum_in scrambles every cycle after capture.
        sum_in = 49'd40960000;
        wait_busy(300, nb);
        chk("iso_busy", (nb > 0), 1);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (rms_valid === 1'b1) begin
                n = i;
                break;
            end
            sum_in = {$urandom, $urandom};
        end
        chk("iso_latency", n, 20);
        chk("iso_rms", rms, 100);

        // Gating.
        window_full = 1'b0;
        sum_in = 49'd61968384;
        bad = 1'b0;
        repeat (1000) begin
            @(negedge clk);
            if (rms_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        chk("gated_quiet", bad, 0);
        window_full = 1'b1;
        wait_valid(400, n);
        chk("ungate_latency", n, 276);
        chk("ungate_rms", rms, 123);

        // Reset during iteration 7.
        sum_in = 49'd4096000000;
        wait_busy(300, nb);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_rms", rms, 0);
        chk("midrst_valid", rms_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_peak", peak, 0);
        @(negedge clk);
        rst = 1'b0;
        sum_in = 49'd1024000000;
        wait_valid(400, n);
        chk("postrst_latency", n, 276);
        chk("postrst_rms", rms, 500);

        // Peak hold.
        peak_clr = 1'b1;
        @(negedge clk);
        peak_clr = 1'b0;
        chk("peak_clr_idle", peak, 0);
        run_vec(49'd4096000000, 19'd1000, "pk_rms_1000");
        chk("peak_a", peak, PK ? 1000 : 0);
        run_vec(49'd1024000000, 19'd500, "pk_rms_500");
        chk("peak_b", peak, PK ? 1000 : 0);
        run_vec(49'd16384000000, 19'd2000, "pk_rms_2000");
        chk("peak_c", peak, PK ? 2000 : 0);

        sum_in = 49'd368640000;
        wait_busy(300, nb);
        peak_clr = 1'b1;
        wait_valid(40, n);
        peak_clr = 1'b0;
        chk("clr_done_latency", n, 20);
        chk("clr_done_rms", rms, 300);
        chk("clr_done_peak", peak, PK ? 300 : 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
